// File: rtl/gpu_font_pkg.sv
// ---------------------------------------------------------------------------
// gpu_font_pkg
// Shared font-geometry constants and the font_bit_fetch state encoding.
// Imported by the ALU-stage flash address calculator and by font_bit_fetch.
//   ADDR_BITS  : width of a glyph bit address into font flash
//   WORD_W     : flash data word width (power of two)
//   SEL_BITS   : bit-select field width, log2(WORD_W)
//   WADDR_BITS : flash word address width
// ---------------------------------------------------------------------------
package gpu_font_pkg;

    localparam int ADDR_BITS      = 26;
    localparam int WORD_W         = 16;
    localparam int SEL_BITS       = $clog2(WORD_W);
    localparam int WADDR_BITS     = ADDR_BITS - SEL_BITS;
    localparam int CHAR_W         = 64;
    localparam int CHAR_H         = 128;
    localparam int CHARS_PER_FONT = 256;
    localparam int BITS_PER_FONT  = CHAR_W * CHAR_H * CHARS_PER_FONT;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } fetch_state_t;

    // Upper address bits select the flash word.
    function automatic logic [WADDR_BITS-1:0] word_addr(input logic [ADDR_BITS-1:0] a);
        return a[ADDR_BITS-1:SEL_BITS];
    endfunction

    // Lower address bits select the bit inside the word, LSB-first.
    function automatic logic [SEL_BITS-1:0] bit_sel(input logic [ADDR_BITS-1:0] a);
        return a[SEL_BITS-1:0];
    endfunction

    // Which font a glyph bit address falls in.
    function automatic int unsigned font_index(input logic [ADDR_BITS-1:0] a);
        return int'(a) / BITS_PER_FONT;
    endfunction

endpackage

// File: rtl/font_bit_fetch_if.sv
// ---------------------------------------------------------------------------
// font_bit_fetch_if
// Groups the three handshakes of font_bit_fetch:
//   req_*  : bit address request from pipe_2_alu (valid/ready)
//   mem_*  : flash word read (rd_en/gnt request, rd_valid data pulse)
//   pix_*  : pixel result to the raster stage (valid/ready)
// Modports: slave = font_bit_fetch itself, master = its environment.
// ---------------------------------------------------------------------------
interface font_bit_fetch_if;
    import gpu_font_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_BITS-1:0]  req_bit_addr;
    logic                  mem_rd_en;
    logic                  mem_rd_gnt;
    logic [WADDR_BITS-1:0] mem_addr;
    logic                  mem_rd_valid;
    logic [WORD_W-1:0]     mem_rd_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_bit;
    logic [ADDR_BITS-1:0]  pix_addr;

    modport slave (
        input  req_valid, req_bit_addr, mem_rd_gnt, mem_rd_valid, mem_rd_data, pix_ready,
        output req_ready, mem_rd_en, mem_addr, pix_valid, pix_bit, pix_addr
    );

    modport master (
        output req_valid, req_bit_addr, mem_rd_gnt, mem_rd_valid, mem_rd_data, pix_ready,
        input  req_ready, mem_rd_en, mem_addr, pix_valid, pix_bit, pix_addr
    );

endinterface

// File: rtl/font_bit_fetch.sv
// ---------------------------------------------------------------------------
// font_bit_fetch
// Takes a glyph bit address, reads the containing 16-bit word from font
// flash and returns the addressed bit as one pixel. One request in flight.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : font_bit_fetch_if.slave (req_*, mem_*, pix_* handshakes)
// Optional build macro FONT_BIT_FETCH_WORD_CACHE_EN keeps the last fetched
// word so requests into the same word answer without a flash read.
// ---------------------------------------------------------------------------
module font_bit_fetch
    import gpu_font_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    font_bit_fetch_if.slave bus
);

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 pix_bit_q;
    logic                 accept;
    logic                 take_data;
    logic                 hit;

`ifdef FONT_BIT_FETCH_WORD_CACHE_EN
    logic                  cache_valid;
    logic [WADDR_BITS-1:0] cache_waddr;
    logic [WORD_W-1:0]     cache_word;

    assign hit = cache_valid && (cache_waddr == word_addr(bus.req_bit_addr));
`else
    assign hit = 1'b0;
`endif

    // State register; reset aborts any transaction in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A grant arriving together with read data in RD_REQ
    // is taken as a complete read and skips RD_WAIT. Read data arriving in
    // IDLE or RESP is ignored, which also drops a read left over by reset.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        take_data  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = hit ? RESP : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus.mem_rd_gnt) begin
                    if (bus.mem_rd_valid) begin
                        take_data  = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (bus.mem_rd_valid) begin
                    take_data  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.pix_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request address and result bit. The latched address doubles as the
    // flash word address and as the echoed pixel address.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            pix_bit_q <= 1'b0;
`ifdef FONT_BIT_FETCH_WORD_CACHE_EN
            cache_valid <= 1'b0;
            cache_waddr <= '0;
            cache_word  <= '0;
`endif
        end else begin
            if (accept) begin
                addr_q <= bus.req_bit_addr;
`ifdef FONT_BIT_FETCH_WORD_CACHE_EN
                if (hit) begin
                    pix_bit_q <= cache_word[bit_sel(bus.req_bit_addr)];
                end
`endif
            end
            if (take_data) begin
                pix_bit_q <= bus.mem_rd_data[bit_sel(addr_q)];
`ifdef FONT_BIT_FETCH_WORD_CACHE_EN
                cache_valid <= 1'b1;
                cache_waddr <= word_addr(addr_q);
                cache_word  <= bus.mem_rd_data;
`endif
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_rd_en = (state == RD_REQ);
    assign bus.pix_valid = (state == RESP);
    assign bus.mem_addr  = word_addr(addr_q);
    assign bus.pix_bit   = pix_bit_q;
    assign bus.pix_addr  = addr_q;

endmodule

// File: tb/tb_font_bit_fetch.sv
// ---------------------------------------------------------------------------
// tb_font_bit_fetch
// Self-checking bench for font_bit_fetch. Randomised requests, flash delays
// and data words are checked against a word/bit arithmetic model of the
// font flash read. Build with FONT_BIT_FETCH_WORD_CACHE_EN to also exercise
// the word cache.
// ---------------------------------------------------------------------------
module tb_font_bit_fetch;

`ifdef FONT_BIT_FETCH_WORD_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests_run;
    int   tests_failed;

    bit          m_cache_valid;
    int unsigned m_cache_word;
    logic [15:0] m_cache_data;

    font_bit_fetch_if bus();

    font_bit_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: bit N of font flash is bit (N mod 16) of word (N / 16).
    // With the cache build, a request into the last fetched word is a hit.
    function automatic void model_txn(input logic [25:0] a, input logic [15:0] d,
                                      output logic exp_bit, output bit exp_hit);
        int unsigned word = int'(a) / 16;
        int unsigned pos  = int'(a) % 16;
        exp_hit = CACHE_ON && m_cache_valid && (m_cache_word == word);
        if (exp_hit) begin
            exp_bit = ((m_cache_data >> pos) & 16'h1) != 16'h0;
        end else begin
            exp_bit = ((d >> pos) & 16'h1) != 16'h0;
            if (CACHE_ON) begin
                m_cache_valid = 1'b1;
                m_cache_word  = word;
                m_cache_data  = d;
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.mem_rd_gnt   = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.pix_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst           = 1'b0;
        m_cache_valid = 1'b0;
    endtask

    // Drives one request and acts as the flash: grant after gnt_dly cycles
    // of mem_rd_en, data dat_dly cycles after the grant (0 = same cycle).
    // Latency is counted in cycles from the accepting edge.
    task automatic run_txn(input logic [25:0] a, input logic [15:0] d,
                           input int gnt_dly, input int dat_dly,
                           output logic [21:0] maddr_o, output logic bit_o,
                           output logic [25:0] paddr_o, output int en_cnt,
                           output int lat, output bit timed_out, output bit acc_ok);
        int  gnt_cyc;
        bit  granted;
        bit  sent;
        en_cnt    = 0;
        lat       = 0;
        timed_out = 1'b1;
        granted   = 1'b0;
        sent      = 1'b0;
        gnt_cyc   = 0;
        maddr_o   = '0;
        bit_o     = 1'b0;
        paddr_o   = '0;
        acc_ok    = bus.req_ready;
        bus.req_valid    = 1'b1;
        bus.req_bit_addr = a;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_bit_addr = 26'($urandom);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            bus.mem_rd_gnt   = 1'b0;
            bus.mem_rd_valid = 1'b0;
            bus.mem_rd_data  = 16'($urandom);
            if (bus.pix_valid) begin
                lat       = cyc;
                bit_o     = bus.pix_bit;
                paddr_o   = bus.pix_addr;
                timed_out = 1'b0;
                break;
            end
            if (bus.mem_rd_en) begin
                en_cnt++;
                maddr_o = bus.mem_addr;
                if (!granted && en_cnt > gnt_dly) begin
                    granted        = 1'b1;
                    gnt_cyc        = cyc;
                    bus.mem_rd_gnt = 1'b1;
                    if (dat_dly == 0) begin
                        bus.mem_rd_valid = 1'b1;
                        bus.mem_rd_data  = d;
                        sent             = 1'b1;
                    end
                end
            end else if (granted && !sent && (cyc - gnt_cyc) >= dat_dly) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = d;
                sent             = 1'b1;
            end
            @(negedge clk);
        end
        bus.mem_rd_gnt   = 1'b0;
        bus.mem_rd_valid = 1'b0;
        if (!timed_out) begin
            bus.pix_ready = 1'b1;
            @(negedge clk);
            bus.pix_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst              = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_bit_addr = 26'h2AAAAAA;
        bus.mem_rd_gnt   = 1'b1;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 16'hFFFF;
        bus.pix_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready got %b want 1", bus.req_ready); end
        tests_run++; if (bus.mem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_rd_en got %b want 0", bus.mem_rd_en); end
        tests_run++; if (bus.mem_addr !== 22'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        tests_run++; if (bus.pix_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pix_valid got %b want 0", bus.pix_valid); end
        tests_run++; if (bus.pix_bit !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pix_bit got %b want 0", bus.pix_bit); end
        tests_run++; if (bus.pix_addr !== 26'h0) begin tests_failed++; $display("[TB] FAIL reset_pix_addr got %h want 0", bus.pix_addr); end
        bus.req_valid    = 1'b0;
        bus.mem_rd_gnt   = 1'b0;
        bus.mem_rd_valid = 1'b0;
        rst              = 1'b0;
        m_cache_valid    = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.req_ready !== 1'b1 || bus.mem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_release_idle got ready=%b rd_en=%b want 1/0", bus.req_ready, bus.mem_rd_en); end
    endtask

    task automatic test_bit_select();
        logic [25:0] a;
        logic [15:0] data_tab [2];
        logic [21:0] maddr;
        logic [25:0] paddr;
        logic        b, exp_b;
        bit          hit, to, acc;
        int          en, lat;
        a = 26'h0400015;
        data_tab[0] = 16'h0020;
        data_tab[1] = 16'hFFDF;
        for (int i = 0; i < 2; i++) begin
            do_reset();
            model_txn(a, data_tab[i], exp_b, hit);
            run_txn(a, data_tab[i], 2, 1, maddr, b, paddr, en, lat, to, acc);
            tests_run++; if (to !== 1'b0 || acc !== 1'b1) begin tests_failed++; $display("[TB] FAIL bitsel_handshake got timeout=%b accepted=%b want 0/1", to, acc); end
            tests_run++; if (maddr !== 22'h040001) begin tests_failed++; $display("[TB] FAIL bitsel_mem_addr got %h want 040001", maddr); end
            tests_run++; if (en !== 3) begin tests_failed++; $display("[TB] FAIL bitsel_rd_en_cycles got %0d want 3", en); end
            tests_run++; if (lat !== 5) begin tests_failed++; $display("[TB] FAIL bitsel_latency got %0d want 5", lat); end
            tests_run++; if (b !== exp_b) begin tests_failed++; $display("[TB] FAIL bitsel_pix_bit data=%h got %b want %b", data_tab[i], b, exp_b); end
            tests_run++; if (paddr !== a) begin tests_failed++; $display("[TB] FAIL bitsel_pix_addr got %h want %h", paddr, a); end
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] a;
        logic [15:0] d;
        logic        exp_b;
        bit          hit;
        do_reset();
        a = 26'($urandom);
        d = 16'($urandom);
        model_txn(a, d, exp_b, hit);
        bus.req_valid    = 1'b1;
        bus.req_bit_addr = a;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.mem_rd_gnt = 1'b1;
        @(negedge clk);
        bus.mem_rd_gnt   = 1'b0;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = d;
        @(negedge clk);
        bus.mem_rd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (bus.pix_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_pix_valid cycle %0d got %b want 1", i, bus.pix_valid); end
            tests_run++; if (bus.pix_bit !== exp_b || bus.pix_addr !== a) begin tests_failed++; $display("[TB] FAIL bp_pix_stable cycle %0d got bit=%b addr=%h want %b/%h", i, bus.pix_bit, bus.pix_addr, exp_b, a); end
            tests_run++; if (bus.req_ready !== 1'b0 || bus.mem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_no_new_req cycle %0d got ready=%b rd_en=%b want 0/0", i, bus.req_ready, bus.mem_rd_en); end
            bus.req_valid    = 1'b1;
            bus.req_bit_addr = ~a;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.pix_ready = 1'b0;
        tests_run++; if (bus.pix_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release got valid=%b ready=%b rd_en=%b want 0/1/0", bus.pix_valid, bus.req_ready, bus.mem_rd_en); end
    endtask

    task automatic test_combined();
        logic [25:0] a, paddr;
        logic [15:0] d;
        logic [21:0] maddr;
        logic        b, exp_b;
        bit          hit, to, acc;
        int          en, lat, g;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            a = 26'($urandom);
            d = 16'($urandom);
            g = $urandom_range(0, 3);
            model_txn(a, d, exp_b, hit);
            run_txn(a, d, g, 0, maddr, b, paddr, en, lat, to, acc);
            tests_run++; if (to !== 1'b0) begin tests_failed++; $display("[TB] FAIL comb_timeout got %b want 0", to); end
            tests_run++; if (lat !== g + 2) begin tests_failed++; $display("[TB] FAIL comb_latency gnt_dly=%0d got %0d want %0d", g, lat, g + 2); end
            tests_run++; if (en !== g + 1) begin tests_failed++; $display("[TB] FAIL comb_rd_en_cycles got %0d want %0d", en, g + 1); end
            tests_run++; if (b !== exp_b) begin tests_failed++; $display("[TB] FAIL comb_pix_bit addr=%h got %b want %b", a, b, exp_b); end
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] a, paddr;
        logic [15:0] d;
        logic [21:0] maddr;
        logic        b, exp_b;
        bit          hit, to, acc;
        int          en, lat;
        do_reset();
        a = 26'($urandom);
        bus.req_valid    = 1'b1;
        bus.req_bit_addr = a;
        @(negedge clk);
        bus.req_valid = 1'b0;
        tests_run++; if (bus.mem_rd_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_rd_en got %b want 1", bus.mem_rd_en); end
        bus.mem_rd_gnt = 1'b1;
        @(negedge clk);
        bus.mem_rd_gnt = 1'b0;
        rst            = 1'b1;
        m_cache_valid  = 1'b0;
        @(negedge clk);
        rst              = 1'b0;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 16'hFFFF;
        @(negedge clk);
        bus.mem_rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (bus.pix_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_idle cycle %0d got valid=%b ready=%b rd_en=%b want 0/1/0", i, bus.pix_valid, bus.req_ready, bus.mem_rd_en); end
            @(negedge clk);
        end
        a = 26'($urandom);
        d = 16'($urandom);
        model_txn(a, d, exp_b, hit);
        run_txn(a, d, 0, 1, maddr, b, paddr, en, lat, to, acc);
        tests_run++; if (to !== 1'b0 || b !== exp_b) begin tests_failed++; $display("[TB] FAIL rstmid_next_txn got timeout=%b bit=%b want 0/%b", to, b, exp_b); end
    endtask

    task automatic test_boundary();
        logic [25:0] addr_tab [2];
        logic [15:0] data_tab [2];
        logic [25:0] paddr;
        logic [21:0] maddr;
        logic        b, exp_b;
        bit          hit, to, acc;
        int          en, lat;
        do_reset();
        addr_tab[0] = 26'h3FFFFFF; data_tab[0] = 16'h8000;
        addr_tab[1] = 26'h0000000; data_tab[1] = 16'h0001;
        for (int i = 0; i < 2; i++) begin
            model_txn(addr_tab[i], data_tab[i], exp_b, hit);
            run_txn(addr_tab[i], data_tab[i], 1, 2, maddr, b, paddr, en, lat, to, acc);
            tests_run++; if (to !== 1'b0) begin tests_failed++; $display("[TB] FAIL bound_timeout addr=%h got %b want 0", addr_tab[i], to); end
            tests_run++; if (maddr !== 22'(addr_tab[i] / 16)) begin tests_failed++; $display("[TB] FAIL bound_mem_addr got %h want %h", maddr, 22'(addr_tab[i] / 16)); end
            tests_run++; if (b !== exp_b || b !== 1'b1) begin tests_failed++; $display("[TB] FAIL bound_pix_bit addr=%h got %b want 1", addr_tab[i], b); end
            tests_run++; if (paddr !== addr_tab[i]) begin tests_failed++; $display("[TB] FAIL bound_pix_addr got %h want %h", paddr, addr_tab[i]); end
        end
    endtask

`ifdef FONT_BIT_FETCH_WORD_CACHE_EN
    task automatic test_cache();
        logic [25:0] addr_tab [3];
        int          en_tab   [3];
        int          lat_tab  [3];
        logic [25:0] paddr;
        logic [15:0] d;
        logic [21:0] maddr;
        logic        b, exp_b;
        bit          hit, to, acc;
        int          en, lat, en_total;
        do_reset();
        addr_tab[0] = 26'h0000010; en_tab[0] = 1; lat_tab[0] = 3;
        addr_tab[1] = 26'h000001F; en_tab[1] = 0; lat_tab[1] = 1;
        addr_tab[2] = 26'h0000020; en_tab[2] = 1; lat_tab[2] = 3;
        en_total = 0;
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            model_txn(addr_tab[i], d, exp_b, hit);
            run_txn(addr_tab[i], d, 0, 1, maddr, b, paddr, en, lat, to, acc);
            if (i < 2) en_total += en;
            tests_run++; if (en !== en_tab[i] || lat !== lat_tab[i]) begin tests_failed++; $display("[TB] FAIL cache_timing addr=%h got rd_en=%0d lat=%0d want %0d/%0d", addr_tab[i], en, lat, en_tab[i], lat_tab[i]); end
            tests_run++; if (b !== exp_b) begin tests_failed++; $display("[TB] FAIL cache_pix_bit addr=%h got %b want %b", addr_tab[i], b, exp_b); end
        end
        tests_run++; if (en_total !== 1) begin tests_failed++; $display("[TB] FAIL cache_single_read got %0d want 1", en_total); end
        tests_run++; if (maddr !== 22'h000002) begin tests_failed++; $display("[TB] FAIL cache_miss_addr got %h want 000002", maddr); end
    endtask
`endif

    task automatic test_random();
        logic [25:0] a, prev, paddr;
        logic [15:0] d;
        logic [21:0] maddr;
        logic        b, exp_b;
        bit          hit, to, acc;
        int          en, lat, g, k;
        prev = 26'($urandom);
        for (int i = 0; i < 24; i++) begin
            a = 26'($urandom);
            if ($urandom_range(0, 2) == 0) a = {prev[25:4], a[3:0]};
            prev = a;
            d = 16'($urandom);
            g = $urandom_range(0, 3);
            k = $urandom_range(0, 3);
            model_txn(a, d, exp_b, hit);
            run_txn(a, d, g, k, maddr, b, paddr, en, lat, to, acc);
            tests_run++; if (to !== 1'b0 || acc !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_handshake #%0d got timeout=%b accepted=%b want 0/1", i, to, acc); end
            tests_run++; if (b !== exp_b) begin tests_failed++; $display("[TB] FAIL rand_pix_bit #%0d addr=%h data=%h got %b want %b", i, a, d, b, exp_b); end
            tests_run++; if (paddr !== a) begin tests_failed++; $display("[TB] FAIL rand_pix_addr #%0d got %h want %h", i, paddr, a); end
            tests_run++; if (en !== (hit ? 0 : g + 1)) begin tests_failed++; $display("[TB] FAIL rand_rd_en_cycles #%0d got %0d want %0d", i, en, hit ? 0 : g + 1); end
            tests_run++; if (lat !== (hit ? 1 : g + k + 2)) begin tests_failed++; $display("[TB] FAIL rand_latency #%0d got %0d want %0d", i, lat, hit ? 1 : g + k + 2); end
            if (!hit) begin
                tests_run++; if (maddr !== 22'(a / 16)) begin tests_failed++; $display("[TB] FAIL rand_mem_addr #%0d got %h want %h", i, maddr, 22'(a / 16)); end
            end
            bus.mem_rd_valid = 1'($urandom);
            bus.mem_rd_data  = 16'($urandom);
            @(negedge clk);
            bus.mem_rd_valid = 1'b0;
            tests_run++; if (bus.pix_valid !== 1'b0 || bus.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_idle_stray_data #%0d got valid=%b ready=%b want 0/1", i, bus.pix_valid, bus.req_ready); end
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        m_cache_valid    = 1'b0;
        m_cache_word     = 0;
        m_cache_data     = '0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_bit_addr = '0;
        bus.mem_rd_gnt   = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        bus.pix_ready    = 1'b0;
        test_reset();
        test_bit_select();
        test_backpressure();
        test_combined();
        test_reset_mid();
        test_boundary();
`ifdef FONT_BIT_FETCH_WORD_CACHE_EN
        test_cache();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
